// File: rtl/sobel_pkg.sv
// Shared widths, types and the 1-2-1 kernel helper for sobel_stream_engine.
package sobel_pkg;

  localparam int SOBEL_PIX_W = 8;
  localparam int GRAD_W      = SOBEL_PIX_W + 3;
  localparam int MAG_W       = SOBEL_PIX_W + 4;
  localparam logic [SOBEL_PIX_W-1:0] PIX_MAX = {SOBEL_PIX_W{1'b1}};

  typedef logic [SOBEL_PIX_W-1:0]   pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [MAG_W-1:0]         mag_t;

  // a + 2b + c is at most 4*PIX_MAX, so the difference of two sums always fits grad_t.
  function automatic grad_t kernel_sum(input pix_t a, input pix_t b, input pix_t c);
    grad_t sa, sb, sc;
    sa = $signed({{(GRAD_W-SOBEL_PIX_W){1'b0}}, a});
    sb = $signed({{(GRAD_W-SOBEL_PIX_W){1'b0}}, b});
    sc = $signed({{(GRAD_W-SOBEL_PIX_W){1'b0}}, c});
    return sa + (sb <<< 1) + sc;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row delay memory: per column, tap1 holds row r-1 and tap2 holds row r-2.
module sobel_line_buffer #(
  parameter int  PIX_W = 8,
  parameter int  IMG_W = 64,
  localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    col_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] tap1_o,
  output logic [PIX_W-1:0] tap2_o
);

  logic [PIX_W-1:0] row1_q [IMG_W];
  logic [PIX_W-1:0] row2_q [IMG_W];

  assign tap1_o = row1_q[col_i];
  assign tap2_o = row2_q[col_i];

  // NOTE: the arrays have no reset; the top never uses a tap before both rows of the frame are written.
  // NOTE: non-blocking assignment lets row2 capture the old row1 value on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      row2_q[col_i] <= row1_q[col_i];
      row1_q[col_i] <= pix_i;
    end
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel magnitude engine; define SOBEL_THRESH_EN to binarise the output against thresh.
// PIX_W must equal sobel_pkg::SOBEL_PIX_W, which sizes the gradient arithmetic.
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int PIX_W = SOBEL_PIX_W,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_eof,
  input  logic [PIX_W-1:0] thresh
);

  localparam int               LB_AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  logic             advance, accept;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d, pos_col, pos_row;
  pix_t [8:0]       win_q, win_d;
  logic             win_vld_q, win_vld_d, win_eof_q, win_eof_d;
  logic             out_valid_q, out_valid_d, out_eof_q, out_eof_d;
  pix_t             out_pix_q, out_pix_d;
  pix_t             tap1, tap2;
  grad_t            gx, gy, ax, ay;
  mag_t             mag;
  pix_t             mag_sat;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign pos_col = in_sof ? '0 : col_q;
  assign pos_row = in_sof ? '0 : row_q;

  sobel_line_buffer #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en_i (accept),
    .col_i   (pos_col[LB_AW-1:0]),
    .pix_i   (in_pix),
    .tap1_o  (tap1),
    .tap2_o  (tap2)
  );

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    col_d     = col_q;
    row_d     = row_q;
    win_d     = win_q;
    win_vld_d = win_vld_q;
    win_eof_d = win_eof_q;
    if (accept) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      win_d[0]  = win_q[1];
      win_d[1]  = win_q[2];
      win_d[2]  = tap2;
      win_d[3]  = win_q[4];
      win_d[4]  = win_q[5];
      win_d[5]  = tap1;
      win_d[6]  = win_q[7];
      win_d[7]  = win_q[8];
      win_d[8]  = in_pix;
      win_vld_d = (pos_row >= CNT_TWO) && (pos_col >= CNT_TWO);
      win_eof_d = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    end else if (advance) begin
      win_vld_d = 1'b0;  // stage 2 has taken this window; do not emit it twice
    end
  end

  always_comb begin
    gx      = kernel_sum(win_q[2], win_q[5], win_q[8]) - kernel_sum(win_q[0], win_q[3], win_q[6]);
    gy      = kernel_sum(win_q[6], win_q[7], win_q[8]) - kernel_sum(win_q[0], win_q[1], win_q[2]);
    ax      = gx[GRAD_W-1] ? -gx : gx;
    ay      = gy[GRAD_W-1] ? -gy : gy;
    mag     = {1'b0, ax} + {1'b0, ay};
    mag_sat = (|mag[MAG_W-1:PIX_W]) ? PIX_MAX : mag[PIX_W-1:0];

    out_valid_d = out_valid_q;
    out_eof_d   = out_eof_q;
    out_pix_d   = out_pix_q;
    if (advance) begin
      out_valid_d = win_vld_q;
      out_eof_d   = win_vld_q && win_eof_q;
`ifdef SOBEL_THRESH_EN
      out_pix_d   = (mag_sat >= thresh) ? PIX_MAX : '0;
`else
      out_pix_d   = mag_sat;
`endif
    end
  end

`ifndef SOBEL_THRESH_EN
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_vld_q   <= 1'b0;
      win_eof_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_vld_q   <= win_vld_d;
      win_eof_q   <= win_eof_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      out_pix_q   <= out_pix_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;
  assign out_pix   = out_pix_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Scoreboard bench for sobel_stream_engine on an 8x8 image with hand-derived expected gradients.
module tb_sobel_stream_engine;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int CNT_W = 3;

  typedef enum int {IMG_CONST, IMG_VSTEP, IMG_HSTEP, IMG_RAMP, IMG_DIAG} img_e;
  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             eof;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_sof;
  logic             out_valid, out_ready, out_eof;
  logic [PIX_W-1:0] in_pix, out_pix, thresh;

  exp_t sb_q[$];
  int   checks = 0, errors = 0, cyc = 0, pops = 0, stall_cnt = 0;
  int   present_cyc = -1, first_out_cyc = -1;
  bit   lat_arm = 1'b0;

  sobel_stream_engine #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_eof   (out_eof),
    .thresh    (thresh)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pixel(input img_e k, input int r, input int c);
    case (k)
      IMG_CONST: return 8'd100;
      IMG_VSTEP: return (c >= 4) ? 8'd255 : 8'd0;
      IMG_HSTEP: return (r >= 4) ? 8'd255 : 8'd0;
      IMG_RAMP:  return 8'(c * 10);
      default:   return 8'(r * 3 + c * 5);
    endcase
  endfunction

  // Hand-derived magnitudes per image for the window centred on (r,c).
  function automatic logic [7:0] expect_pix(input img_e k, input int r, input int c);
    logic [7:0] v;
    case (k)
      IMG_CONST: v = 8'd0;
      IMG_VSTEP: v = (c == 3 || c == 4) ? 8'd255 : 8'd0;
      IMG_HSTEP: v = (r == 3 || r == 4) ? 8'd255 : 8'd0;
      IMG_RAMP:  v = 8'd80;
      default:   v = 8'd64;
    endcase
`ifdef SOBEL_THRESH_EN
    v = (v >= thresh) ? 8'hFF : 8'h00;
`endif
    return v;
  endfunction

  task automatic send_pix(input img_e k, input int r, input int c, input logic sof);
    int waits;
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_pix   = pixel(k, r, c);
    in_sof   = sof;
    #4;
    while (!in_ready) begin
      waits++;
      if (waits > 200) begin
        $display("FAIL accept_timeout: in_ready low for %0d cycles, expected high", waits);
        $fatal(1, "input stalled");
      end
      @(negedge clk);
      #4;
    end
    if (r == 2 && c == 2) present_cyc = cyc;
    if (r >= 2 && c >= 2)
      sb_q.push_back('{pix: expect_pix(k, r - 1, c - 1), eof: (r == IMG_H - 1 && c == IMG_W - 1)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic feed_frame(input img_e k, input int n_pix, input logic sof_first);
    for (int i = 0; i < n_pix; i++)
      send_pix(k, i / IMG_W, i % IMG_W, (i == 0) ? sof_first : 1'b0);
  endtask

  task automatic stall_out(input int after_cycles, input int len);
    repeat (after_cycles) @(negedge clk);
    out_ready = 1'b0;
    repeat (len) @(negedge clk);
    out_ready = 1'b1;
  endtask

  task automatic drain(input string name, input int exp_pops);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      #4;
      n++;
    end
    repeat (2) @(negedge clk);
    check({name, "_drain"}, sb_q.size(), 0);
    check({name, "_count"}, pops, exp_pops);
    pops = 0;
  endtask

  initial begin : monitor
    exp_t       e;
    logic       stalled;
    logic [7:0] held_pix;
    logic       held_eof;
    stalled  = 1'b0;
    held_pix = '0;
    held_eof = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (stalled && reset) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_pix", out_pix, held_pix);
        check("stall_hold_eof", out_eof, held_eof);
      end
      if (out_valid && lat_arm) begin
        first_out_cyc = cyc;
        lat_arm       = 1'b0;
      end
      if (out_valid && !out_ready) begin
        stall_cnt++;
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got out_pix=%0d eof=%0d, expected no output", out_pix, out_eof);
        end else begin
          e = sb_q.pop_front();
          pops++;
          check("out_pix", out_pix, e.pix);
          check("out_eof", out_eof, e.eof);
        end
      end
      stalled  = out_valid && !out_ready && reset;
      held_pix = out_pix;
      held_eof = out_eof;
    end
  end

  initial begin : stimulus
    in_valid  = 1'b0;
    in_pix    = '0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    thresh    = 8'd128;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_out_eof", out_eof, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    lat_arm = 1'b1;
    feed_frame(IMG_CONST, 64, 1'b1);
    drain("const", 36);
    check("latency", first_out_cyc - present_cyc, 2);

    feed_frame(IMG_VSTEP, 64, 1'b1);
    drain("vstep", 36);
    feed_frame(IMG_RAMP, 64, 1'b1);
    drain("ramp", 36);
    feed_frame(IMG_HSTEP, 64, 1'b1);
    drain("hstep", 36);
    feed_frame(IMG_DIAG, 64, 1'b1);
    drain("diag", 36);

    stall_cnt = 0;
    fork
      feed_frame(IMG_VSTEP, 64, 1'b1);
      stall_out(30, 5);
    join
    drain("backpressure", 36);
    check("stall_cycles", stall_cnt, 5);

    // Abandon a step frame at pixel 20 with in_sof on the first pixel of a ramp frame.
    feed_frame(IMG_VSTEP, 20, 1'b1);
    feed_frame(IMG_RAMP, 64, 1'b1);
    drain("resync", 38);

    feed_frame(IMG_DIAG, 30, 1'b1);
    @(negedge clk);
    #1;
    check("pre_reset_valid", out_valid, 1);
    out_ready = 1'b0;
    reset     = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_pix", out_pix, 0);
    check("midrst_out_eof", out_eof, 0);
    check("midrst_in_ready", in_ready, 1);
    sb_q.delete();
    pops = 0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    reset     = 1'b1;
    feed_frame(IMG_DIAG, 64, 1'b0);
    drain("post_reset", 36);

    thresh = 8'd0;
    feed_frame(IMG_CONST, 64, 1'b1);
    drain("thresh_zero", 36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_stream_engine.md
Name: sobel_stream_engine

Overview:
- Streaming successor to the fixed 72-bit-window `main_sobel`.
- Accepts a raster pixel stream (one pixel per beat) with a valid/ready handshake.
- Builds 3x3 windows internally from two line buffers and emits the Sobel gradient magnitude for every interior pixel.
- Sits between the pixel memory/source and the result sink. It removes the need for the source to assemble 9-pixel windows.

Parameters:
- PIX_W, 8: pixel width in bits (in and out).
- IMG_W, 64: image width in pixels (>=3).
- IMG_H, 64: image height in pixels (>=3).
- CNT_W, 7: width of the row/column counters; must satisfy 2^CNT_W >= max(IMG_W, IMG_H).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  source has a pixel.
- in_ready  out  1  engine accepts a pixel this cycle.
- in_pix  in  PIX_W  pixel, raster order.
- in_sof  in  1  marks the first pixel of a frame; sampled only on accept.
- out_valid  out  1  out_pix is valid.
- out_ready  in  1  sink accepts.
- out_pix  out  PIX_W  gradient magnitude.
- out_eof  out  1  high with the last interior output of a frame.
- thresh  in  PIX_W  binarisation level (used only with SOBEL_THRESH_EN).

Behaviour:
- Reset (async assert, sync release): all outputs 0, except in_ready = 1. Counters, window and pipeline valids are cleared. Line-buffer contents are don't-care.
- Handshake:
  - Transfer occurs on a clock edge where valid && ready.
  - advance = !out_valid || out_ready, and in_ready = advance (combinational).
  - While out_valid && !out_ready: out_pix and out_eof hold stable, and no input is accepted.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance on each accepted pixel. col wraps to 0 with row+1; after (IMG_H-1, IMG_W-1) both wrap to 0.
- Resync: an accepted pixel with in_sof = 1 is forced to position (0,0) regardless of counter state, and counters continue from there. in_sof on a pixel already at (0,0) has no further effect.
- Window:
  - Per accept, the shifting 3x3 window receives the column {linebuf1[col], linebuf0[col], in_pix}.
  - Then linebuf1[col] <= linebuf0[col] and linebuf0[col] <= in_pix.
  - Window indices p0..p8 run row-major, with p0 at top-left (row r-2, col c-2) and p8 = current pixel.
- Window-valid flag: set on the accept of pixel (r,c) when r >= 2 and c >= 2. The window then centres on (r-1, c-1). Border pixels produce no output.
- Outputs per frame: exactly (IMG_W-2)*(IMG_H-2).
- Arithmetic (stage 2):
  - Gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6); Gy = (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2).
  - Both are signed, PIX_W+3 bits.
  - mag = |Gx| + |Gy|, unsigned PIX_W+4 bits, saturated to 2^PIX_W - 1.
- Latency: 2 clocks when unstalled. The window register updates on the accepting edge; out_pix/out_valid register on the next advancing edge.
- out_eof: 1 exactly with the output whose centre is (IMG_H-2, IMG_W-2).
- Stall: the whole pipeline (window, stage-2, counters) freezes when advance = 0. No bubble insertion and no data loss.
- Reset mid-frame: clears all state. The next accepted pixel is treated as (0,0), even without in_sof, and no partial-frame output is emitted.

Optional Feature:
- Macro SOBEL_THRESH_EN.
- Defined: out_pix = (mag_sat >= thresh) ? all-ones : 0.
- Undefined: out_pix = mag_sat, and the thresh port exists but is ignored.
- Latency is unchanged in both builds.

Decomposition:
- Package sobel_pkg holds:
  - derived widths GRAD_W = PIX_W+3 and MAG_W = PIX_W+4;
  - the saturation constant PIX_MAX;
  - the kernel-sum function used for Gx/Gy.
- Sub-module sobel_line_buffer (params PIX_W, IMG_W): a two-row delay memory with one write and one read per column index, holding row r-1 and row r-2 taps. It does not reset; the top qualifies its outputs with the row counter.

Test Plan:
- Constant image, IMG_W = IMG_H = 8, all pixels 100, out_ready = 1 -> 36 outputs, all 0; out_eof only on the 36th; first out_valid 2 clocks after the accept of pixel (2,2).
- Vertical step (cols 0-3 = 0, cols 4-7 = 255), 8x8 -> centre cols 3 and 4 give Gx = 1020, saturated to 255; all other outputs 0.
- Ramp image, pixel = col*10 -> every interior output = 80 (Gx = 80, Gy = 0).
- Backpressure: out_ready low for 5 cycles mid-frame -> out_pix/out_eof held constant, in_ready = 0, and the output sequence is identical to the unstalled run.
- in_sof asserted at pixel index 20 of a frame, then a fresh 8x8 frame -> 36 correct outputs for the new frame; reset asserted mid-frame -> outputs return to reset values immediately, and the next frame yields 36 correct outputs.
- SOBEL_THRESH_EN with thresh = 128, step image -> step columns output 255, others 0; thresh = 0 -> all 36 outputs 255.
